four_input_gate_bist: RTL

Synthesizable built-in self-test controller for a 4-input combinational gate.
- Drives all 16 input patterns onto the gate and waits a programmable settle time for each.
- Samples the gate output and compares it with an expected truth table.
- Reports pass/fail, a mismatch count and the first failing pattern.
- Sits beside the gate instance: pattern outputs go to the gate inputs, and the gate output returns to dut_e.

---
 rtl/four_input_gate_pkg.sv | 18 +
 rtl/four_input_nor_gate_a.sv | 12 +
 rtl/four_input_gate_bist.sv | 116 +++++++++++
 3 files changed

// File: rtl/four_input_gate_pkg.sv
// Shared types and constants for the four-input gate self-test controller.
package four_input_gate_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [15:0] TT_NOR  = 16'h0001;
    localparam logic [15:0] TT_OR   = 16'hFFFE;
    localparam logic [15:0] TT_AND  = 16'h8000;
    localparam logic [15:0] TT_NAND = 16'h7FFF;

    localparam int N_PATTERNS = 16;

endpackage

// File: rtl/four_input_nor_gate_a.sv
// Reference four-input NOR gate used as the circuit under test beside the BIST.
module four_input_nor_gate_a (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic e
);

    assign e = ~(a | b | c | d);

endmodule

// File: rtl/four_input_gate_bist.sv
// Built-in self-test controller: sweeps all 16 input patterns over a 4-input gate,
// waits a settle time per pattern, and checks the gate output against a truth table.
module four_input_gate_bist
    import four_input_gate_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] TRUTH_TABLE   = TT_NOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    output logic       dut_d,
    input  logic       dut_e,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail,
    output logic       first_fail_valid
);

    // With no settle time the SETTLE state is skipped entirely, so its terminal count is unused.
    localparam logic [3:0] SETTLE_LAST  = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_PATTERN = 4'(N_PATTERNS - 1);

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic [3:0] pattern;
    logic [3:0] settle_cnt;
    logic       mismatch;
    logic [4:0] err_next;

    assign dut_a = pattern[3];
    assign dut_b = pattern[2];
    assign dut_c = pattern[1];
    assign dut_d = pattern[0];

    assign mismatch = (dut_e != TRUTH_TABLE[pattern]);
    assign err_next = err_count + 5'(mismatch);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (pattern == LAST_PATTERN) begin
                    state_next = DONE;
                end else if (SETTLE_CYCLES != 0) begin
                    state_next = SETTLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            pattern          <= 4'd0;
            settle_cnt       <= 4'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 5'd0;
            first_fail       <= 4'd0;
            first_fail_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                pattern          <= 4'd0;
                settle_cnt       <= 4'd0;
                busy             <= 1'b1;
                done             <= 1'b0;
                pass             <= 1'b0;
                err_count        <= 5'd0;
                first_fail       <= 4'd0;
                first_fail_valid <= 1'b0;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt + 4'd1;
            end else if (state == SAMPLE) begin
                if (mismatch) begin
                    err_count <= err_next;
                    if (!first_fail_valid) begin
                        first_fail       <= pattern;
                        first_fail_valid <= 1'b1;
                    end
                end
                // The final verdict must fold in the sample taken this very cycle.
                if (pattern == LAST_PATTERN) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_next == 5'd0);
                end else begin
                    pattern    <= pattern + 4'd1;
                    settle_cnt <= 4'd0;
                end
            end
        end
    end

endmodule
